stage_mm_ws: RTL and testbench
==============================

Name: stage_mm_ws

Overview:
- Parametrised successor memory stage: sits between STAGE_EX and STAGE_WB.
- Adds a req/ack RAM handshake with arbitrary wait states and a wait-state timeout.
- Adds byte/halfword/word accesses with byte enables and sign/zero extension.
- Holds completed results while WB is stalled and raises stall_out back to the upstream pipeline while an access is outstanding.

Parameters:
- DATA_W, 32, data width; must be a multiple of 8 (bench covers 32).
- ADDR_W, 32, memory address width.
- REG_ADDR_W, 5, register-file address width.
- MAX_WAIT, 15, ack wait cycles tolerated before abort; counter width is clog2(MAX_WAIT+1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  global enable; when low, nothing updates and no new request is launched.
- stall  in  1  downstream stall; freezes WB output registers.
- flush  in  1  instruction from EX is squashed.
- is_load, is_store  in  1 each  memory op type; never both high.
- size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- is_unsigned  in  1  zero-extend loads when high, sign-extend when low.
- reg_wr  in  1  ALU result writes rd.
- reg_addr_rd  in  REG_ADDR_W  destination register.
- reg_data_rd  in  DATA_W  ALU result, or store data.
- alu_mem_addr  in  ADDR_W  effective address.
- stall_out  out  1  freeze EX and earlier stages.
- ffw_MM_data_wr  out  DATA_W  forwarding value: the aligned load result or reg_data_rd.
- mem_req  out  1  access request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  word-aligned address; low clog2(DATA_W/8) bits are zero.
- mem_be  out  DATA_W/8  byte enables.
- mem_data_w  out  DATA_W  lane-replicated store data.
- mem_data_r  in  DATA_W  read data; valid with mem_ack.
- mem_ack  in  1  access complete; may assert in the same cycle as mem_req.
- mem_timeout  out  1  one-cycle pulse when an access is aborted.
- out_reg_wr, out_reg_addr_rd, out_reg_data_rd, out_flush  out  to STAGE_WB.

Behaviour:
- Reset values:
  - state IDLE; wait counter 0.
  - mem_req 0, mem_timeout 0.
  - out_reg_wr 0, out_flush 1; other outputs 0.
- A memory op is live when en && (is_load||is_store) && !flush.
- FSM state IDLE:
  - mem_req is driven combinationally from the inputs when a memory op is live.
  - mem_ack in the same cycle gives a zero-wait completion: the WB registers load that edge if !stall, else go to HOLD.
  - No mem_ack: latch addr, be, data, rd, size and sign into request registers and go to WAIT.
  - stall_out = live && !mem_ack.
- FSM state WAIT:
  - mem_req=1, driven from the latched registers, which stay stable until ack.
  - stall_out=1.
  - Counter increments each cycle.
  - mem_ack with !stall: write WB registers and go to IDLE.
  - mem_ack with stall: capture the result and go to HOLD.
  - Counter reaches MAX_WAIT with no ack: drop mem_req, pulse mem_timeout, present out_flush=1 and out_reg_wr=0 to WB, go to IDLE.
- FSM state HOLD:
  - mem_req=0, stall_out=1.
  - When stall drops, write the captured result to WB and go to IDLE.
- Non-memory ops, and flushed ops, pass EX to WB in one cycle when en && !stall:
  - out_reg_wr = reg_wr && !flush.
  - out_flush = flush.
- Loads set out_reg_wr=1.
- Lane offset is addr[1:0].
- Byte: mem_be = 1<<off; the data byte is replicated to all lanes.
- Half: mem_be = 0011<<(2*addr[1]); the data halfword is replicated.
- Word: mem_be = all ones.
- Load extraction selects the same lanes, then sign- or zero-extends to DATA_W.
- ffw_MM_data_wr is meaningful only when stall_out=0.
- rst_n low in any state forces IDLE next edge, aborts any outstanding request (no timeout pulse), and ignores a late ack.
- mem_ack while in IDLE with no request is ignored.

Optional Feature:
- MM_MISALIGN_TRAP_EN defined:
  - A misaligned access is a halfword with addr[0]=1, or a word with addr[1:0]!=0.
  - It issues no mem_req.
  - It pulses output mem_misalign for 1 cycle.
  - It passes to WB with out_flush=1 and out_reg_wr=0.
- Undefined:
  - The port mem_misalign is absent.
  - Offending low address bits are ignored: half uses addr[1], word uses lane 0.

Test Plan:
- Word load at addr 0x10, mem_ack in the same cycle, mem_data_r=0xDEADBEEF -> stall_out never high; next edge out_reg_data_rd=0xDEADBEEF, out_reg_wr=1.
- Signed byte load at addr 0x13, data 0x80FFFFFF, ack after 3 cycles -> stall_out high 3 cycles; mem_addr=0x10 stable throughout; result 0xFFFFFF80; with is_unsigned, result 0x00000080.
- Half store at addr 0x22, data 0x0000ABCD -> mem_we=1, mem_be=1100, mem_data_w=0xABCDABCD.
- Load with no ack for MAX_WAIT=15 cycles -> mem_timeout pulses once; out_flush=1; mem_req low the next cycle; then IDLE.
- Ack arrives while stall=1 -> HOLD; WB registers unchanged until stall drops, then the load value appears 1 edge later.
- Load with flush=1 -> mem_req stays 0; out_flush=1, out_reg_wr=0. Repeat with rst_n asserted mid-WAIT -> IDLE, out_flush=1.

Source files
------------

// File: rtl/stage_mm_ws.sv
// stage_mm_ws: memory stage between EX and WB with a req/ack RAM handshake,
// wait-state timeout, sub-word accesses and a hold buffer for a stalled WB.
// Optional build macro MM_MISALIGN_TRAP_EN: misaligned half/word accesses are
// trapped (no request, mem_misalign pulse, squashed to WB) instead of having
// their offending low address bits ignored.
module stage_mm_ws #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MAX_WAIT   = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  input  logic                  reg_wr,
  input  logic [REG_ADDR_W-1:0] reg_addr_rd,
  input  logic [DATA_W-1:0]     reg_data_rd,
  input  logic [ADDR_W-1:0]     alu_mem_addr,
  output logic                  stall_out,
  output logic [DATA_W-1:0]     ffw_MM_data_wr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [DATA_W-1:0]     mem_data_w,
  input  logic [DATA_W-1:0]     mem_data_r,
  input  logic                  mem_ack,
  output logic                  mem_timeout,
`ifdef MM_MISALIGN_TRAP_EN
  output logic                  mem_misalign,
`endif
  output logic                  out_reg_wr,
  output logic [REG_ADDR_W-1:0] out_reg_addr_rd,
  output logic [DATA_W-1:0]     out_reg_data_rd,
  output logic                  out_flush
);

  localparam int unsigned BeW   = DATA_W / 8;
  localparam int unsigned OffW  = $clog2(BeW);
  localparam int unsigned CntW  = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  function automatic logic [BeW-1:0] calc_be(input logic [1:0] sz, input logic [OffW-1:0] off);
    logic [BeW-1:0] be;
    case (sz)
      2'b00:   be = {{(BeW-1){1'b0}}, 1'b1} << off;
      2'b01:   be = {{(BeW-2){1'b0}}, 2'b11} << {off[OffW-1:1], 1'b0};
      default: be = '1;
    endcase
    return be;
  endfunction

  function automatic logic [DATA_W-1:0] repl(input logic [1:0] sz, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    case (sz)
      2'b00:   r = {BeW{d[7:0]}};
      2'b01:   r = {(BeW/2){d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] d, input logic [1:0] sz,
                                                input logic [OffW-1:0] off, input logic uns);
    logic [DATA_W-1:0] sh_b;
    logic [DATA_W-1:0] sh_h;
    logic [DATA_W-1:0] r;
    sh_b = d >> {off, 3'b000};
    sh_h = d >> {off[OffW-1:1], 4'b0000};
    case (sz)
      2'b00:   r = {{(DATA_W-8){~uns & sh_b[7]}}, sh_b[7:0]};
      2'b01:   r = {{(DATA_W-16){~uns & sh_h[15]}}, sh_h[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  timeout_q, timeout_d;
  // request registers: the op as presented by EX when the access was launched
  logic [ADDR_W-1:0]     addr_q;
  logic [1:0]            size_q;
  logic                  uns_q, load_q, store_q, regwr_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0]     data_q;
  // result captured while WB is stalled
  logic [DATA_W-1:0]     res_q;
  logic                  res_wr_q;
  // WB output registers
  logic                  wb_wr_q;
  logic [REG_ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0]     wb_data_q;
  logic                  wb_flush_q;

  logic                  live, mis_c, in_wait, req_c, stall_c, cap, hold_we;
  logic                  wb_we, wb_wr, wb_flush;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]     wb_data;
  logic [ADDR_W-1:0]     s_addr;
  logic [1:0]            s_size;
  logic                  s_uns, s_load, s_store, s_regwr;
  logic [REG_ADDR_W-1:0] s_rd;
  logic [DATA_W-1:0]     s_data, result;
  logic [OffW-1:0]       s_off;
  logic                  result_wr;

  assign live = en && (is_load || is_store) && !flush;

`ifdef MM_MISALIGN_TRAP_EN
  assign mis_c = (is_load || is_store) &&
                 ((size == 2'b01 && alu_mem_addr[0]) || (size[1] && |alu_mem_addr[OffW-1:0]));
  assign mem_misalign = (state_q == StIdle) && live && mis_c;
`else
  assign mis_c = 1'b0;
`endif

  // While waiting, every access attribute comes from the request registers.
  assign in_wait   = (state_q == StWait);
  assign s_addr    = in_wait ? addr_q  : alu_mem_addr;
  assign s_size    = in_wait ? size_q  : size;
  assign s_uns     = in_wait ? uns_q   : is_unsigned;
  assign s_load    = in_wait ? load_q  : is_load;
  assign s_store   = in_wait ? store_q : is_store;
  assign s_regwr   = in_wait ? regwr_q : reg_wr;
  assign s_rd      = in_wait ? rd_q    : reg_addr_rd;
  assign s_data    = in_wait ? data_q  : reg_data_rd;
  assign s_off     = s_addr[OffW-1:0];
  assign result    = s_load ? extract(mem_data_r, s_size, s_off, s_uns) : s_data;
  assign result_wr = s_load ? 1'b1 : s_regwr;

  // Next-state, handshake outputs and WB write selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    cap       = 1'b0;
    hold_we   = 1'b0;
    wb_we     = 1'b0;
    wb_wr     = 1'b0;
    wb_flush  = 1'b0;
    wb_addr   = s_rd;
    wb_data   = result;
    unique case (state_q)
      StIdle: begin
        if (live && !mis_c) begin
          req_c   = 1'b1;
          stall_c = !mem_ack;
          cap     = 1'b1;
          if (mem_ack) begin
            if (!stall) begin
              wb_we = 1'b1;
              wb_wr = result_wr;
            end else begin
              hold_we = 1'b1;
              state_d = StHold;
            end
          end else begin
            state_d = StWait;
            cnt_d   = CntW'(1);
          end
        end else if (en && !stall) begin
          // plain pass-through; squashed and trapped ops never write rd
          wb_we    = 1'b1;
          wb_wr    = reg_wr && !flush && !mis_c;
          wb_flush = flush || mis_c;
          wb_data  = reg_data_rd;
        end
      end
      StWait: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (mem_ack) begin
          cnt_d = '0;
          if (!stall) begin
            wb_we   = 1'b1;
            wb_wr   = result_wr;
            state_d = StIdle;
          end else begin
            hold_we = 1'b1;
            state_d = StHold;
          end
        end else if (cnt_q == CntW'(MAX_WAIT - 1)) begin
          // abort: the edge ending the MAX_WAIT-th request cycle
          timeout_d = 1'b1;
          cnt_d     = '0;
          wb_we     = 1'b1;
          wb_flush  = 1'b1;
          wb_data   = '0;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        stall_c = 1'b1;
        if (!stall) begin
          wb_we   = 1'b1;
          wb_wr   = res_wr_q;
          wb_addr = rd_q;
          wb_data = res_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, request, hold and WB registers; everything freezes while en is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      load_q     <= 1'b0;
      store_q    <= 1'b0;
      regwr_q    <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
      res_q      <= '0;
      res_wr_q   <= 1'b0;
      wb_wr_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      wb_flush_q <= 1'b1;
    end else begin
      timeout_q <= en ? timeout_d : 1'b0;
      if (en) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        if (cap) begin
          addr_q  <= alu_mem_addr;
          size_q  <= size;
          uns_q   <= is_unsigned;
          load_q  <= is_load;
          store_q <= is_store;
          regwr_q <= reg_wr;
          rd_q    <= reg_addr_rd;
          data_q  <= reg_data_rd;
        end
        if (hold_we) begin
          res_q    <= result;
          res_wr_q <= result_wr;
        end
        if (wb_we) begin
          wb_wr_q    <= wb_wr;
          wb_addr_q  <= wb_addr;
          wb_data_q  <= wb_data;
          wb_flush_q <= wb_flush;
        end
      end
    end
  end

  assign stall_out       = stall_c;
  assign ffw_MM_data_wr  = result;
  assign mem_req         = req_c;
  assign mem_we          = req_c && s_store;
  assign mem_addr        = req_c ? {s_addr[ADDR_W-1:OffW], {OffW{1'b0}}} : '0;
  assign mem_be          = req_c ? calc_be(s_size, s_off) : '0;
  assign mem_data_w      = req_c ? repl(s_size, s_data) : '0;
  assign mem_timeout     = timeout_q;
  assign out_reg_wr      = wb_wr_q;
  assign out_reg_addr_rd = wb_addr_q;
  assign out_reg_data_rd = wb_data_q;
  assign out_flush       = wb_flush_q;

endmodule

// File: tb/tb_stage_mm_ws.sv
// Directed bench for stage_mm_ws: zero-wait vector table plus hand-written
// wait-state, timeout, WB-stall hold, flush/enable and reset-abort sequences.
module tb_stage_mm_ws;

  logic        clk, rst_n, en, stall, flush, is_load, is_store, is_unsigned, reg_wr;
  logic [1:0]  size;
  logic [4:0]  reg_addr_rd;
  logic [31:0] reg_data_rd, alu_mem_addr;
  logic        stall_out, mem_req, mem_we, mem_ack, mem_timeout;
  logic [31:0] ffw_MM_data_wr, mem_addr, mem_data_w, mem_data_r;
  logic [3:0]  mem_be;
  logic        out_reg_wr, out_flush;
  logic [4:0]  out_reg_addr_rd;
  logic [31:0] out_reg_data_rd;

  int checks   = 0;
  int failures = 0;

  stage_mm_ws dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .stall          (stall),
    .flush          (flush),
    .is_load        (is_load),
    .is_store       (is_store),
    .size           (size),
    .is_unsigned    (is_unsigned),
    .reg_wr         (reg_wr),
    .reg_addr_rd    (reg_addr_rd),
    .reg_data_rd    (reg_data_rd),
    .alu_mem_addr   (alu_mem_addr),
    .stall_out      (stall_out),
    .ffw_MM_data_wr (ffw_MM_data_wr),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_be         (mem_be),
    .mem_data_w     (mem_data_w),
    .mem_data_r     (mem_data_r),
    .mem_ack        (mem_ack),
    .mem_timeout    (mem_timeout),
    .out_reg_wr     (out_reg_wr),
    .out_reg_addr_rd(out_reg_addr_rd),
    .out_reg_data_rd(out_reg_data_rd),
    .out_flush      (out_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] mdw;
    logic [31:0] maddr;
    logic [31:0] res;
    logic        wr;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    en = 1'b1; stall = 1'b0; flush = 1'b0; is_load = 1'b0; is_store = 1'b0;
    size = 2'b00; is_unsigned = 1'b0; reg_wr = 1'b0; reg_addr_rd = '0;
    reg_data_rd = '0; alu_mem_addr = '0; mem_ack = 1'b0; mem_data_r = '0;
  endtask

  initial begin
    int stalls, reqs, tos, to_at, to_seen;
    //          ld    st    sz     uns   addr   din           rdata         be       mdw           maddr  res           wr
    vecs[0] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 4'b1111, 32'h0,        32'h10, 32'hDEADBEEF, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'h80FFFFFF, 4'b1000, 32'h0,        32'h10, 32'hFFFFFF80, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'h80FFFFFF, 4'b1000, 32'h0,        32'h10, 32'h00000080, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0,        32'h80011234, 4'b1100, 32'h0,        32'h20, 32'hFFFF8001, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0,        32'h80011234, 4'b0011, 32'h0,        32'h20, 32'h00001234, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD, 32'h0,        4'b1100, 32'hABCDABCD, 32'h20, 32'h0000ABCD, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h41, 32'h12345678, 32'h0,        4'b0010, 32'h78787878, 32'h40, 32'h12345678, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h80, 32'hCAFEF00D, 32'h0,        4'b1111, 32'hCAFEF00D, 32'h80, 32'hCAFEF00D, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h30, 32'h0,        32'h01234567, 4'b1111, 32'h0,        32'h30, 32'h01234567, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0,        32'h0000F00F, 4'b0011, 32'h0,        32'h10, 32'hFFFFF00F, 1'b1};

    rst_n = 1'b0;
    set_idle();
    tick();
    tick();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_timeout", {31'd0, mem_timeout}, 32'd0);
    chk("rst_out_reg_wr", {31'd0, out_reg_wr}, 32'd0);
    chk("rst_out_flush", {31'd0, out_flush}, 32'd1);
    chk("rst_out_data", out_reg_data_rd, 32'd0);
    chk("rst_stall_out", {31'd0, stall_out}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Zero-wait accesses: ack in the request cycle.
    for (int i = 0; i < 10; i++) begin
      is_load = vecs[i].ld; is_store = vecs[i].st; size = vecs[i].sz;
      is_unsigned = vecs[i].uns; alu_mem_addr = vecs[i].addr; reg_data_rd = vecs[i].din;
      reg_addr_rd = 5'(i + 1); mem_ack = 1'b1; mem_data_r = vecs[i].rdata;
      #3;
      chk($sformatf("v%0d_mem_req", i), {31'd0, mem_req}, 32'd1);
      chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].st});
      chk($sformatf("v%0d_mem_be", i), {28'd0, mem_be}, {28'd0, vecs[i].be});
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].maddr);
      chk($sformatf("v%0d_mem_data_w", i), mem_data_w, vecs[i].mdw);
      chk($sformatf("v%0d_stall_out", i), {31'd0, stall_out}, 32'd0);
      chk($sformatf("v%0d_ffw", i), ffw_MM_data_wr, vecs[i].res);
      tick();
      chk($sformatf("v%0d_out_data", i), out_reg_data_rd, vecs[i].res);
      chk($sformatf("v%0d_out_wr", i), {31'd0, out_reg_wr}, {31'd0, vecs[i].wr});
      chk($sformatf("v%0d_out_rd", i), {27'd0, out_reg_addr_rd}, 32'(i + 1));
      chk($sformatf("v%0d_out_flush", i), {31'd0, out_flush}, 32'd0);
    end
    set_idle();
    tick();

    // Byte load with ack in the third request cycle; inputs scrambled while waiting.
    for (int u = 0; u < 2; u++) begin
      is_load = 1'b1; size = 2'b00; is_unsigned = u[0]; alu_mem_addr = 32'h13;
      reg_addr_rd = 5'd9; mem_ack = 1'b0; mem_data_r = 32'h0;
      stalls = 0;
      for (int k = 0; k < 3; k++) begin
        if (k > 0) begin
          alu_mem_addr = 32'hFFF0; size = 2'b10; is_unsigned = ~u[0];
        end
        if (k == 2) begin
          mem_ack = 1'b1; mem_data_r = 32'h80FFFFFF;
        end
        #3;
        if (stall_out) stalls++;
        chk($sformatf("ws%0d_mem_addr_c%0d", u, k), mem_addr, 32'h10);
        tick();
      end
      set_idle();
      chk($sformatf("ws%0d_stall_cycles", u), 32'(stalls), 32'd3);
      chk($sformatf("ws%0d_out_data", u), out_reg_data_rd, (u == 0) ? 32'hFFFFFF80 : 32'h00000080);
      chk($sformatf("ws%0d_out_wr", u), {31'd0, out_reg_wr}, 32'd1);
      chk($sformatf("ws%0d_out_rd", u), {27'd0, out_reg_addr_rd}, 32'd9);
      chk($sformatf("ws%0d_stall_after", u), {31'd0, stall_out}, 32'd0);
      tick();
    end

    // Timeout: no ack ever arrives.
    is_load = 1'b1; size = 2'b10; alu_mem_addr = 32'h50;
    reqs = 0; tos = 0; to_at = -1;
    for (int k = 0; k < 30; k++) begin
      #3;
      if (mem_req) reqs++;
      if (mem_timeout) begin
        tos++;
        to_at = k;
        chk("to_out_flush", {31'd0, out_flush}, 32'd1);
        chk("to_out_wr", {31'd0, out_reg_wr}, 32'd0);
        chk("to_mem_req", {31'd0, mem_req}, 32'd0);
      end
      tick();
      if (k == 0) is_load = 1'b0;
    end
    chk("to_req_cycles", 32'(reqs), 32'd15);
    chk("to_pulses", 32'(tos), 32'd1);
    chk("to_pulse_cycle", 32'(to_at), 32'd15);

    // Ack while WB is stalled: result held until stall drops.
    set_idle();
    reg_data_rd = 32'h0BAD0BAD;
    tick();
    chk("hold_pre_data", out_reg_data_rd, 32'h0BAD0BAD);
    is_load = 1'b1; size = 2'b10; alu_mem_addr = 32'h60; reg_addr_rd = 5'd12;
    tick();
    is_load = 1'b0; stall = 1'b1; mem_ack = 1'b1; mem_data_r = 32'h11223344;
    tick();
    mem_ack = 1'b0; mem_data_r = 32'h0;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk($sformatf("hold_data_c%0d", k), out_reg_data_rd, 32'h0BAD0BAD);
      chk($sformatf("hold_stall_out_c%0d", k), {31'd0, stall_out}, 32'd1);
      chk($sformatf("hold_mem_req_c%0d", k), {31'd0, mem_req}, 32'd0);
      tick();
    end
    stall = 1'b0;
    #3;
    chk("hold_release_stall_out", {31'd0, stall_out}, 32'd1);
    tick();
    chk("hold_out_data", out_reg_data_rd, 32'h11223344);
    chk("hold_out_wr", {31'd0, out_reg_wr}, 32'd1);
    chk("hold_out_rd", {27'd0, out_reg_addr_rd}, 32'd12);
    chk("hold_out_flush", {31'd0, out_flush}, 32'd0);
    chk("hold_stall_after", {31'd0, stall_out}, 32'd0);

    // Flushed load, pass-through ALU op, WB stall freeze, enable low.
    set_idle();
    is_load = 1'b1; flush = 1'b1; alu_mem_addr = 32'h70; reg_wr = 1'b1;
    #3;
    chk("fl_mem_req", {31'd0, mem_req}, 32'd0);
    chk("fl_stall_out", {31'd0, stall_out}, 32'd0);
    tick();
    chk("fl_out_flush", {31'd0, out_flush}, 32'd1);
    chk("fl_out_wr", {31'd0, out_reg_wr}, 32'd0);
    set_idle();
    reg_wr = 1'b1; reg_addr_rd = 5'd7; reg_data_rd = 32'h55AA55AA;
    #3;
    chk("alu_ffw", ffw_MM_data_wr, 32'h55AA55AA);
    tick();
    chk("alu_out_wr", {31'd0, out_reg_wr}, 32'd1);
    chk("alu_out_rd", {27'd0, out_reg_addr_rd}, 32'd7);
    chk("alu_out_data", out_reg_data_rd, 32'h55AA55AA);
    chk("alu_out_flush", {31'd0, out_flush}, 32'd0);
    stall = 1'b1; reg_data_rd = 32'h12121212; reg_addr_rd = 5'd3;
    tick();
    chk("stall_freeze_data", out_reg_data_rd, 32'h55AA55AA);
    chk("stall_freeze_rd", {27'd0, out_reg_addr_rd}, 32'd7);
    set_idle();
    en = 1'b0; is_load = 1'b1; alu_mem_addr = 32'h10;
    #3;
    chk("en_low_mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("en_low_out_data", out_reg_data_rd, 32'h55AA55AA);

    // Reset in the middle of a wait, then a stray late ack.
    set_idle();
    tick();
    is_load = 1'b1; size = 2'b10; alu_mem_addr = 32'h90;
    tick();
    is_load = 1'b0;
    #3;
    chk("rw_mem_req_wait", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rw_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rw_out_flush", {31'd0, out_flush}, 32'd1);
    chk("rw_out_wr", {31'd0, out_reg_wr}, 32'd0);
    chk("rw_stall_out", {31'd0, stall_out}, 32'd0);
    mem_ack = 1'b1; mem_data_r = 32'hFFFFFFFF;
    tick();
    mem_ack = 1'b0;
    chk("rw_late_ack_wr", {31'd0, out_reg_wr}, 32'd0);
    chk("rw_late_ack_data", out_reg_data_rd, 32'd0);
    to_seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (mem_timeout) to_seen++;
      tick();
    end
    chk("rw_no_timeout", 32'(to_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
